vga_sync_gen: RTL

Raster timing generator that drives the display side of the pong graphics pipeline. It divides the system clock down to a pixel-rate enable and runs the horizontal and vertical scan counters. From those counters it produces active-low hsync/vsync, the `video_on` blanking flag and the `pixel_x`/`pixel_y` coordinates consumed by the graphics/animation block. Default parameters give 640x480 @ 60 Hz from a 100 MHz clock.

---
 rtl/vga_sync_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// Raster timing generator for the display side of the pong graphics
// pipeline. A clock divider produces a pixel-rate enable, which advances the
// horizontal and vertical scan counters. The counters drive the active-low
// sync pulses, the visible-area flag and the pixel coordinates.
// The defaults give 640x480 @ 60 Hz from a 100 MHz clock.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous active-high reset
//   p_tick     out  pixel enable, one clk high every CLK_DIV clks
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  current coordinate lies inside the visible area
//   pixel_x    out  horizontal count, 0..H_TOTAL-1
//   pixel_y    out  vertical count, 0..V_TOTAL-1
//   frame_tick out  one-clk pulse on the last pixel of each frame
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       p_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0]       HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]       HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0]       VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]       VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [10:0]      H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0]      V_VIS    = 11'(V_DISPLAY);

  // The coordinate outputs are 10 bits wide, so larger rasters cannot be
  // represented and are rejected at elaboration.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_check
    $error("vga_sync_gen: CLK_DIV must be in 1..16");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             h_end, v_end;

  assign p_tick = (div_q == DIV_MAX);
  assign h_end  = (x_q == H_MAX);
  assign v_end  = (y_q == V_MAX);

  always_comb begin
    div_d = div_q + 1'b1;
    if (p_tick) begin
      div_d = '0;
    end

    x_d = x_q;
    y_d = y_q;
    if (p_tick) begin
      if (h_end) begin
        x_d = '0;
        // Vertical wrap lands on the same edge as the horizontal wrap.
        y_d = v_end ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end

    // Decoding the next count lets the registered syncs change on the same
    // edge as the coordinates they describe.
    hsync_d = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vsync_d = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = ({1'b0, x_q} < H_VIS) && ({1'b0, y_q} < V_VIS);
  // p_tick qualifies the pulse so it lasts one clk, not CLK_DIV clks.
  assign frame_tick = p_tick && h_end && v_end;

endmodule
